// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

    // Clocks per baud tick, rounded to nearest; 0 flags an unusable setting.
    function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
        longint den;
        den = baud * os;
        if (den <= 0) return 0;
        return int'((clk_hz + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-cycle tick every DIV clocks.
// Latency: first tick DIV clocks after reset or restart.
// Backpressure: none; restart realigns the tick phase.
module uart_baud_gen #(
    parameter int DIV = 33
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running modulo-DIV counter, zeroed on restart so a new bit starts on a full period.
    always_ff @(posedge clock) begin
        if (!reset_n || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver (configurable width/parity/stop bits/oversampling); optional UART_LOOPBACK_EN adds an internal TX->RX loopback port.
// Latency: start bit leaves one clock after the tx handshake; rx_valid rises about 2 clocks after the mid-stop-bit sample.
// Backpressure: tx_ready only in TX idle; a frame completing while rx_valid is held without rx_ready is dropped and sets sticky rx_overrun.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 5_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] DB_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] SB_LAST = 4'(STOP_BITS - 1);
    localparam bit PAR_EN    = (PARITY != int'(NONE));
    localparam bit PAR_ODD_L = (PARITY == int'(ODD));

    if (DIV < 1) begin : g_bad_div
        $error("uart_xcvr: CLK_HZ/(BAUD*OVERSAMPLE) rounds below 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_xcvr: DATA_BITS must be 5..9");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_xcvr: OVERSAMPLE must be even and >= 4");
    end

    // ---------------- TX ----------------
    tx_state_e             tx_state, tx_state_nxt;
    logic [OSW-1:0]        tx_os, tx_os_nxt;
    logic [3:0]            tx_bcnt, tx_bcnt_nxt;
    logic [DATA_BITS-1:0]  tx_sh, tx_sh_nxt;
    logic                  tx_par, tx_par_nxt;
    logic                  tx_line, tx_line_nxt;
    logic                  tx_tick, tx_restart, tx_bit_end;

    uart_baud_gen #(.DIV(DIV)) u_tx_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (tx_restart),
        .tick    (tx_tick)
    );

    assign tx_bit_end = tx_tick && (tx_os == OS_LAST);
    assign tx_ready   = (tx_state == TX_IDLE);

    // TX state and datapath registers; tx_line is registered so the pin never glitches.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_os    <= '0;
            tx_bcnt  <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_os    <= tx_os_nxt;
            tx_bcnt  <= tx_bcnt_nxt;
            tx_sh    <= tx_sh_nxt;
            tx_par   <= tx_par_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

    // TX next state: each bit lasts OVERSAMPLE ticks, baud phase restarted at the handshake.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_os_nxt    = tx_os;
        tx_bcnt_nxt  = tx_bcnt;
        tx_sh_nxt    = tx_sh;
        tx_par_nxt   = tx_par;
        tx_restart   = 1'b0;
        tx_line_nxt  = 1'b1;
        if (tx_tick) begin
            tx_os_nxt = (tx_os == OS_LAST) ? '0 : tx_os + 1'b1;
        end
        case (tx_state)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_nxt = TX_START;
                    tx_sh_nxt    = tx_data;
                    tx_par_nxt   = (^tx_data) ^ PAR_ODD_L;
                    tx_os_nxt    = '0;
                    tx_bcnt_nxt  = '0;
                    tx_restart   = 1'b1;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_nxt = TX_DATA;
                    tx_bcnt_nxt  = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_sh_nxt = tx_sh >> 1;
                    if (tx_bcnt == DB_LAST) begin
                        tx_bcnt_nxt  = '0;
                        tx_state_nxt = PAR_EN ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bcnt_nxt = tx_bcnt + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_nxt = TX_STOP;
                    tx_bcnt_nxt  = '0;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bcnt == SB_LAST) begin
                        tx_state_nxt = TX_IDLE;
                        tx_bcnt_nxt  = '0;
                    end else begin
                        tx_bcnt_nxt = tx_bcnt + 1'b1;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        case (tx_state_nxt)
            TX_START:  tx_line_nxt = 1'b0;
            TX_DATA:   tx_line_nxt = tx_sh_nxt[0];
            TX_PARITY: tx_line_nxt = tx_par_nxt;
            default:   tx_line_nxt = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    rx_state_e             rx_state, rx_state_nxt;
    logic [OSW-1:0]        rx_os, rx_os_nxt;
    logic [3:0]            rx_bcnt, rx_bcnt_nxt;
    logic [DATA_BITS-1:0]  rx_sh, rx_sh_nxt;
    logic                  rx_parbit, rx_parbit_nxt;
    logic                  rx_s1, rx_s2, rx_src;
    logic                  rx_tick, rx_restart, rx_bit_end, rx_done, rx_perr_new;

`ifdef UART_LOOPBACK_EN
    logic lb_q;

    // Loopback selection only changes while both directions are idle, so no frame is cut.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lb_q <= 1'b0;
        end else if (tx_state == TX_IDLE && rx_state == RX_IDLE) begin
            lb_q <= loopback;
        end
    end

    assign rx_src = lb_q ? tx_line : rx;
    assign tx     = lb_q ? 1'b1 : tx_line;
`else
    assign rx_src = rx;
    assign tx     = tx_line;
`endif

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_src;
            rx_s2 <= rx_s1;
        end
    end

    uart_baud_gen #(.DIV(DIV)) u_rx_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (rx_restart),
        .tick    (rx_tick)
    );

    assign rx_bit_end  = rx_tick && (rx_os == OS_LAST);
    assign rx_perr_new = PAR_EN && (((^rx_sh) ^ rx_parbit) != PAR_ODD_L);

    // RX state and shift registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_state  <= RX_IDLE;
            rx_os     <= '0;
            rx_bcnt   <= '0;
            rx_sh     <= '0;
            rx_parbit <= 1'b0;
        end else begin
            rx_state  <= rx_state_nxt;
            rx_os     <= rx_os_nxt;
            rx_bcnt   <= rx_bcnt_nxt;
            rx_sh     <= rx_sh_nxt;
            rx_parbit <= rx_parbit_nxt;
        end
    end

    // RX next state: start edge realigns the baud phase, then every sample lands mid-bit.
    always_comb begin
        rx_state_nxt  = rx_state;
        rx_os_nxt     = rx_os;
        rx_bcnt_nxt   = rx_bcnt;
        rx_sh_nxt     = rx_sh;
        rx_parbit_nxt = rx_parbit;
        rx_restart    = 1'b0;
        rx_done       = 1'b0;
        if (rx_tick) begin
            rx_os_nxt = (rx_os == OS_LAST) ? '0 : rx_os + 1'b1;
        end
        case (rx_state)
            RX_IDLE: begin
                if (!rx_s2) begin
                    rx_state_nxt = RX_START;
                    rx_os_nxt    = '0;
                    rx_restart   = 1'b1;
                end
            end
            RX_START: begin
                if (rx_tick && rx_os == OS_HALF) begin
                    rx_os_nxt = '0;
                    if (rx_s2) begin
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_state_nxt = RX_DATA;
                        rx_bcnt_nxt  = '0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_sh_nxt = {rx_s2, rx_sh[DATA_BITS-1:1]};
                    if (rx_bcnt == DB_LAST) begin
                        rx_bcnt_nxt  = '0;
                        rx_state_nxt = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bcnt_nxt = rx_bcnt + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_bit_end) begin
                    rx_parbit_nxt = rx_s2;
                    rx_state_nxt  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_done      = 1'b1;
                    rx_state_nxt = rx_s2 ? RX_IDLE : RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s2) rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // Output holding register: new frame loads if the slot is free or being drained this cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (rx_done && (!rx_valid || rx_ready)) begin
                rx_valid      <= 1'b1;
                rx_data       <= rx_sh;
                rx_frame_err  <= !rx_s2;
                rx_parity_err <= rx_perr_new;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (rx_valid && rx_ready) begin
                rx_overrun <= 1'b0;
            end else if (rx_done && rx_valid) begin
                rx_overrun <= 1'b1;
            end
        end
    end

endmodule
